// File: rtl/stack_cpu_ctrl.sv
// Multi-cycle control unit for a stack processor; operand stack held internally, ALU external.
// Define STACK_CPU_CTRL_STALL_EN to add rom_ready/ram_ready handshakes for variable-latency memories.
module stack_cpu_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int OPC_W       = 5,
  parameter int STACK_DEPTH = 16,
  localparam int INST_W     = OPC_W + DATA_W,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
`ifdef STACK_CPU_CTRL_STALL_EN
  input  logic              rom_ready,
  input  logic              ram_ready,
`endif
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] pc,
  output logic [SP_W-1:0]   sp,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_rdata,
  output logic              ram_en,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [OPC_W-1:0]  alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_flag
);

  localparam int IDX_W = $clog2(STACK_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_FETCH_W, S_DECODE, S_MEM_RD, S_MEM_W, S_EXEC, S_ERROR
  } state_t;

  state_t state, state_nx;

  logic [INST_W-1:0] ir;
  logic [DATA_W-1:0] stack_mem [STACK_DEPTH];
  logic [ADDR_W-1:0] pc_nx;
  logic [SP_W-1:0]   sp_nx;
  logic              err_nx;
  logic [1:0]        err_code_nx;
  logic              ir_ld;
  logic              stk_we;
  logic [IDX_W-1:0]  stk_idx;
  logic [DATA_W-1:0] stk_data;
  logic              rom_ok;
  logic              ram_ok;
  logic              stall;

`ifdef STACK_CPU_CTRL_STALL_EN
  assign rom_ok = rom_ready;
  assign ram_ok = ram_ready;
  assign stall  = 1'b1;
`else
  assign rom_ok = 1'b1;
  assign ram_ok = 1'b1;
  assign stall  = 1'b0;
`endif

  logic [OPC_W-1:0]  opc;
  logic [DATA_W-1:0] operand;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;
  logic [IDX_W-1:0]  top_idx, nos_idx;
  logic [DATA_W-1:0] top, nos;

  assign opc     = ir[INST_W-1:DATA_W];
  assign operand = ir[DATA_W-1:0];
  assign target  = operand[ADDR_W-1:0];
  assign pc_inc  = pc + ADDR_W'(1);
  assign top_idx = sp[IDX_W-1:0] - IDX_W'(1);
  assign nos_idx = sp[IDX_W-1:0] - IDX_W'(2);
  assign top     = stack_mem[top_idx];
  assign nos     = stack_mem[nos_idx];

  logic is_push, is_pushi, is_pusht, is_pop, is_bin, is_not, is_goto, is_cond, is_halt;
  logic legal, need1, need2, grows, sp_ge1, sp_ge2, full;

  assign is_push  = (opc == OPC_W'(0));
  assign is_pushi = (opc == OPC_W'(1));
  assign is_pusht = (opc == OPC_W'(2));
  assign is_pop   = (opc == OPC_W'(3));
  assign is_bin   = (opc >= OPC_W'(4)) && (opc <= OPC_W'(12));
  assign is_not   = (opc == OPC_W'(13));
  assign is_goto  = (opc == OPC_W'(14));
  assign is_cond  = (opc >= OPC_W'(15)) && (opc <= OPC_W'(19));
  assign is_halt  = (opc == OPC_W'(31));
  assign legal    = is_push | is_pushi | is_pusht | is_pop | is_bin | is_not | is_goto | is_cond | is_halt;
  assign need1    = is_pusht | is_pop | is_not;
  assign need2    = is_bin | is_cond;
  assign grows    = is_push | is_pushi | is_pusht;
  assign sp_ge1   = (sp != '0);
  assign sp_ge2   = (sp >= SP_W'(2));
  assign full     = (sp >= SP_W'(STACK_DEPTH));

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= '0;
      sp       <= '0;
      err      <= 1'b0;
      err_code <= '0;
      ir       <= '0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      sp       <= sp_nx;
      err      <= err_nx;
      err_code <= err_code_nx;
      if (ir_ld) ir <= rom_rdata;
    end
  end

  // Stack storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (!reset && stk_we) stack_mem[stk_idx] <= stk_data;
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    sp_nx       = sp;
    err_nx      = err;
    err_code_nx = err_code;
    ir_ld       = 1'b0;
    stk_we      = 1'b0;
    stk_idx     = sp[IDX_W-1:0];
    stk_data    = operand;
    busy        = 1'b1;
    done        = 1'b0;
    rom_en      = 1'b0;
    rom_addr    = '0;
    ram_en      = 1'b0;
    ram_wren    = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    alu_op      = '0;
    alu_a       = '0;
    alu_b       = '0;
    case (state)
      S_IDLE, S_ERROR: begin
        busy = 1'b0;
        if (start) begin
          state_nx = S_FETCH;
          pc_nx    = '0;
          if (state == S_ERROR) begin
            sp_nx       = '0;
            err_nx      = 1'b0;
            err_code_nx = '0;
          end
        end
      end
      S_FETCH: begin
        rom_en   = 1'b1;
        rom_addr = pc;
        state_nx = S_FETCH_W;
      end
      S_FETCH_W: begin
        rom_en   = stall;
        rom_addr = stall ? pc : '0;
        if (rom_ok) begin
          ir_ld    = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_nx = S_ERROR; err_nx = 1'b1; err_code_nx = 2'b11;
        end else if ((need1 && !sp_ge1) || (need2 && !sp_ge2)) begin
          state_nx = S_ERROR; err_nx = 1'b1; err_code_nx = 2'b01;
        end else if (grows && full) begin
          state_nx = S_ERROR; err_nx = 1'b1; err_code_nx = 2'b10;
        end else begin
          state_nx = is_push ? S_MEM_RD : S_EXEC;
        end
      end
      S_MEM_RD: begin
        ram_en   = 1'b1;
        ram_addr = target;
        state_nx = S_MEM_W;
      end
      S_MEM_W: begin
        ram_en   = stall;
        ram_addr = stall ? target : '0;
        if (ram_ok) begin
          stk_we   = 1'b1;
          stk_data = ram_rdata;
          sp_nx    = sp + SP_W'(1);
          pc_nx    = pc_inc;
          state_nx = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_op   = opc;
        alu_a    = sp_ge1 ? top : '0;
        alu_b    = (sp_ge2 && !is_not) ? nos : '0;
        pc_nx    = pc_inc;
        state_nx = S_FETCH;
        if (is_pushi || is_pusht) begin
          stk_we   = 1'b1;
          stk_data = is_pusht ? top : operand;
          sp_nx    = sp + SP_W'(1);
        end else if (is_pop) begin
          ram_en    = 1'b1;
          ram_wren  = 1'b1;
          ram_addr  = target;
          ram_wdata = top;
          if (ram_ok) begin
            sp_nx = sp - SP_W'(1);
          end else begin
            pc_nx    = pc;
            state_nx = S_EXEC;
          end
        end else if (is_bin) begin
          stk_we   = 1'b1;
          stk_idx  = nos_idx;
          stk_data = alu_result;
          sp_nx    = sp - SP_W'(1);
        end else if (is_not) begin
          stk_we   = 1'b1;
          stk_idx  = top_idx;
          stk_data = alu_result;
        end else if (is_goto) begin
          pc_nx = target;
        end else if (is_cond) begin
          sp_nx = sp - SP_W'(2);
          pc_nx = alu_flag ? target : pc_inc;
        end else if (is_halt) begin
          done     = 1'b1;
          pc_nx    = pc;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    // A reset arriving mid-instruction must not let a RAM access through.
    ram_en   = ram_en & ~reset;
    ram_wren = ram_wren & ~reset;
  end

endmodule
